// File: rtl/result_framer.sv
// result_framer: frames a 32-bit result plus a status byte into a byte stream
// for a UART transmitter, one byte per transmitter handshake.
//
// Frame: HEADER, status, result[31:24], [23:16], [15:8], [7:0] (+ checksum).
// Optional feature macro: RESULT_FRAMER_CHECKSUM_EN appends a seventh byte,
// the XOR of the status byte and the four result bytes (HEADER excluded).
//
// Ports:
//   i_Clk          system clock, rising edge
//   i_Rst          asynchronous active-high reset
//   i_Result_DV    result valid strobe, accepted only while o_Ready is high
//   i_Result       32-bit result word
//   i_Status       status/opcode echo byte
//   o_Ready        high in IDLE, when a result can be accepted
//   o_TX_DV        one-cycle byte-send strobe
//   o_TX_Byte      byte to transmit, held until i_TX_Done is sampled
//   i_TX_Done      transmitter byte-complete pulse
//   o_Frame_Count  completed frames, wraps at 8 bits
//   o_Timeout      sticky abort flag, cleared only by reset
//
// state | meaning
// IDLE  | ready for a new result
// LOAD  | o_TX_DV strobe for the current byte
// WAIT  | waiting for i_TX_Done, timeout counter running

module result_framer #(
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter logic [15:0] TX_TIMEOUT = 16'd4000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Result_DV,
  input  logic [31:0] i_Result,
  input  logic [7:0]  i_Status,
  output logic        o_Ready,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  input  logic        i_TX_Done,
  output logic [7:0]  o_Frame_Count,
  output logic        o_Timeout
);

`ifdef RESULT_FRAMER_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  localparam logic [15:0] TIMER_TC = TX_TIMEOUT - 16'd1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  byte_idx, byte_idx_nxt;
  logic [31:0] result_q, result_nxt;
  logic [7:0]  status_q, status_nxt;
  logic [7:0]  tx_byte, tx_byte_nxt;
  logic [7:0]  frame_count, frame_count_nxt;
  logic        timeout_flag, timeout_nxt;
  logic [15:0] timer, timer_nxt;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [7:0] st,
                                            input logic [31:0] res);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HEADER;
      3'd1:    b = st;
      3'd2:    b = res[31:24];
      3'd3:    b = res[23:16];
      3'd4:    b = res[15:8];
      3'd5:    b = res[7:0];
`ifdef RESULT_FRAMER_CHECKSUM_EN
      3'd6:    b = st ^ res[31:24] ^ res[23:16] ^ res[15:8] ^ res[7:0];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    state_nxt       = state;
    byte_idx_nxt    = byte_idx;
    result_nxt      = result_q;
    status_nxt      = status_q;
    tx_byte_nxt     = tx_byte;
    frame_count_nxt = frame_count;
    timeout_nxt     = timeout_flag;
    timer_nxt       = timer;
    case (state)
      IDLE: begin
        if (i_Result_DV) begin
          result_nxt   = i_Result;
          status_nxt   = i_Status;
          byte_idx_nxt = 3'd0;
          tx_byte_nxt  = HEADER;
          state_nxt    = LOAD;
        end
      end
      LOAD: begin
        timer_nxt = 16'd0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A Done arriving on the terminal timer cycle still completes the byte.
        if (i_TX_Done) begin
          if (byte_idx == LAST_IDX) begin
            frame_count_nxt = frame_count + 8'd1;
            state_nxt       = IDLE;
          end else begin
            byte_idx_nxt = byte_idx + 3'd1;
            tx_byte_nxt  = frame_byte(byte_idx + 3'd1, status_q, result_q);
            state_nxt    = LOAD;
          end
        end else if (timer == TIMER_TC) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= IDLE;
      byte_idx     <= 3'd0;
      result_q     <= 32'd0;
      status_q     <= 8'd0;
      tx_byte      <= 8'h00;
      frame_count  <= 8'd0;
      timeout_flag <= 1'b0;
      timer        <= 16'd0;
    end else begin
      state        <= state_nxt;
      byte_idx     <= byte_idx_nxt;
      result_q     <= result_nxt;
      status_q     <= status_nxt;
      tx_byte      <= tx_byte_nxt;
      frame_count  <= frame_count_nxt;
      timeout_flag <= timeout_nxt;
      timer        <= timer_nxt;
    end
  end

  assign o_Ready       = (state == IDLE);
  assign o_TX_DV       = (state == LOAD);
  assign o_TX_Byte     = tx_byte;
  assign o_Frame_Count = frame_count;
  assign o_Timeout     = timeout_flag;

endmodule

// File: tb/tb_result_framer.sv
module tb_result_framer;

  localparam logic [7:0]  HDR = 8'hA5;
  localparam int          TO  = 40;
`ifdef RESULT_FRAMER_CHECKSUM_EN
  localparam int          NB  = 7;
`else
  localparam int          NB  = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [31:0] res;
  logic [7:0]  stat;
  logic        ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        done;
  logic [7:0]  fcount;
  logic        tout;

  result_framer #(.HEADER(HDR), .TX_TIMEOUT(16'(TO))) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Result_DV(dv), .i_Result(res),
    .i_Status(stat), .o_Ready(ready), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
    .i_TX_Done(done), .o_Frame_Count(fcount), .o_Timeout(tout)
  );

  initial forever #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_busy = 0;
  bit         m_dv = 0;
  logic [7:0] m_bytes[$];
  int         m_wait = 0;
  logic [7:0] m_count = 0;
  bit         m_timeout = 0;
  int         m_frames_total = 0;

  function automatic void build_frame(input logic [7:0] st, input logic [31:0] r);
    m_bytes.delete();
    m_bytes.push_back(HDR);
    m_bytes.push_back(st);
    for (int k = 3; k >= 0; k--) m_bytes.push_back(r[k*8 +: 8]);
    if (NB == 7) m_bytes.push_back(st ^ r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0]);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_dv = 0; m_bytes.delete(); m_wait = 0;
        m_count = 0; m_timeout = 0;
      end else if (!m_busy) begin
        if (dv) begin
          build_frame(stat, res);
          m_busy = 1;
          m_dv = 1;
        end
      end else if (m_dv) begin
        m_dv = 0;
        m_wait = 0;
      end else if (done) begin
        void'(m_bytes.pop_front());
        if (m_bytes.size() == 0) begin
          m_busy = 0;
          m_count = m_count + 8'd1;
          m_frames_total++;
        end else begin
          m_dv = 1;
        end
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_busy = 0;
          m_timeout = 1;
          m_bytes.delete();
        end
      end
    end
  end

  // ---------------- Done responder ----------------
  bit resp_rand = 0;
  int fixed_delay = 10;
  bit withhold = 0;
  int withhold_idx = 0;
  bit noise_en = 0;
  int pending = 0;

  initial begin
    done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      done = 1'b0;
      if (rst) begin
        pending = 0;
      end else if (m_busy && m_dv) begin
        if (withhold && (NB - m_bytes.size()) >= withhold_idx) pending = 0;
        else pending = resp_rand ? int'($urandom_range(1, 4)) : fixed_delay;
        if (noise_en) done = ($urandom_range(0, 3) == 0);
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) done = 1'b1;
      end else if (!m_busy && noise_en) begin
        done = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] seen_q[$];
  int cyc = 0;
  int dv3_cyc = -1;
  int to_cyc = -1;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("ready", ready, m_busy ? 0 : 1);
      chk("tx_dv", tx_dv, m_dv ? 1 : 0);
      if (m_busy) chk("tx_byte", tx_byte, m_bytes[0]);
      chk("frame_count", fcount, m_count);
      chk("timeout", tout, m_timeout ? 1 : 0);
      if (!rst && tx_dv) begin
        seen_q.push_back(tx_byte);
        if (seen_q.size() == 3) dv3_cyc = cyc;
      end
      if (tout && to_cyc < 0) to_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (m_frames_total < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_wait", m_frames_total, target);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_tx_dv", tx_dv, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_count", fcount, 8'h00);
    chk("rst_timeout", tout, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] lit[7];
  int base;
  int n;

  initial begin
    lit[0] = 8'hA5; lit[1] = 8'h01; lit[2] = 8'h12; lit[3] = 8'h34;
    lit[4] = 8'h56; lit[5] = 8'h78; lit[6] = 8'h09;
    rst = 1'b1; dv = 1'b0; res = 32'd0; stat = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("por_ready", ready, 1);
    chk("por_tx_byte", tx_byte, 8'h00);
    chk("por_count", fcount, 8'h00);
    rst = 1'b0;

    // Known frame with 10-clock responder, plus a dropped mid-frame result.
    tick();
    seen_q.delete();
    dv = 1'b1; stat = 8'h01; res = 32'h12345678;
    tick();
    dv = 1'b0;
    repeat (20) tick();
    dv = 1'b1; stat = 8'hFF; res = 32'hDEADBEEF;
    tick();
    dv = 1'b0;
    wait_frames(1, 400);
    chk("lit_nbytes", seen_q.size(), NB);
    for (int i = 0; i < NB; i++)
      if (i < seen_q.size()) chk("lit_byte", seen_q[i], lit[i]);
    tick();
    chk("lit_count", fcount, 8'd1);

    // Randomized traffic with random Done latency and spurious Done pulses.
    resp_rand = 1; noise_en = 1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      dv = ($urandom_range(0, 3) == 0);
      res = $urandom;
      stat = 8'($urandom);
    end
    dv = 1'b0;
    n = 0;
    while (m_busy && n < 200) begin tick(); n++; end
    chk("rand_settle", ready, 1);

    // 256 frames back-to-back with i_Result_DV held high.
    reset_pulse();
    tick();
    base = m_frames_total;
    dv = 1'b1;
    n = 0;
    while (m_frames_total < base + 256 && n < 256 * 40) begin
      tick();
      res = $urandom;
      stat = 8'($urandom);
      n++;
    end
    dv = 1'b0;
    chk("b2b_frames", m_frames_total - base, 256);
    tick();
    tick();
    chk("b2b_wrap", fcount, 8'h00);

    // Withhold Done from the third byte onward: abort by timeout.
    noise_en = 0; resp_rand = 0; fixed_delay = 3;
    withhold = 1; withhold_idx = 2;
    seen_q.delete(); dv3_cyc = -1; to_cyc = -1;
    dv = 1'b1; stat = 8'h5A; res = 32'hCAFEF00D;
    tick();
    dv = 1'b0;
    n = 0;
    while (to_cyc < 0 && n < 200) begin tick(); n++; end
    tick();
    chk("to_flag", tout, 1);
    chk("to_idle", ready, 1);
    chk("to_count", fcount, 8'h00);
    chk("to_nbytes", seen_q.size(), 3);
    chk("to_latency", to_cyc - dv3_cyc, TO + 1);
    withhold = 0;

    // Reset during the WAIT of the fourth byte.
    dv = 1'b1; stat = 8'h3C; res = 32'h0BADF00D;
    tick();
    dv = 1'b0;
    n = 0;
    while (!(m_busy && !m_dv && m_bytes.size() == NB - 3) && n < 200) begin tick(); n++; end
    chk("rst_mid_reached", m_bytes.size(), NB - 3);
    reset_pulse();
    seen_q.delete();
    repeat (30) tick();
    chk("rst_no_dv", seen_q.size(), 0);
    chk("rst_count_after", fcount, 8'h00);

    // A fresh frame after the reset still goes out normally.
    resp_rand = 1;
    dv = 1'b1; stat = 8'h01; res = 32'h12345678;
    tick();
    dv = 1'b0;
    wait_frames(m_frames_total + 1, 200);
    tick();
    chk("post_rst_count", fcount, 8'd1);
    chk("post_rst_hdr", seen_q.size() > 0 ? seen_q[0] : 8'h00, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/result_framer.md
RESULT_FRAMER -- requirements
Module: result_framer

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, meaning the frame start byte sent first in every frame.
REQ-002 SHALL have parameter TX_TIMEOUT, default 16'd4000, meaning the maximum clocks to wait for i_TX_Done before aborting a frame.
REQ-003 SHALL have port i_Clk, input, 1, the single system clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port i_Rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port i_Result_DV, input, 1, result valid strobe.
REQ-006 SHALL have port i_Result, input, 32, result word to send.
REQ-007 SHALL have port i_Status, input, 8, status/opcode echo byte.
REQ-008 SHALL have port o_Ready, output, 1, which is high when a result can be accepted.
REQ-009 SHALL have port o_TX_DV, output, 1, a one-cycle byte-send strobe to the UART transmitter.
REQ-010 SHALL have port o_TX_Byte, output, 8, the byte to transmit.
REQ-011 SHALL have port i_TX_Done, input, 1, the transmitter's byte-complete pulse.
REQ-012 SHALL have port o_Frame_Count, output, 8, the count of frames completed.
REQ-013 SHALL have port o_Timeout, output, 1, a sticky flag set when a frame was aborted.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, WAIT.
REQ-015 In IDLE, o_Ready SHALL be 1; in all other states it SHALL be 0.
REQ-016 Accept SHALL occur when i_Result_DV=1 and o_Ready=1 at an edge; i_Result and i_Status are captured on that edge and the FSM goes to LOAD.
REQ-017 i_Result_DV with o_Ready=0 SHALL be ignored; the result is dropped and captured data is unchanged.
REQ-018 Frame byte order SHALL be HEADER, status, i_Result[31:24], [23:16], [15:8], [7:0], then checksum if enabled.
REQ-019 In LOAD, o_TX_DV=1 for exactly one cycle with the current byte, then the FSM goes to WAIT.
REQ-020 o_TX_Byte SHALL be held stable from the o_TX_DV cycle until i_TX_Done is sampled.
REQ-021 Latency: for an accept at edge N, o_TX_DV with HEADER SHALL be high in the cycle after edge N.
REQ-022 When i_TX_Done=1 in WAIT: if bytes remain, the FSM goes to LOAD with the next byte (o_TX_DV one cycle after Done); on the last byte it goes to IDLE and o_Frame_Count increments.
REQ-023 o_Frame_Count SHALL wrap from 8'hFF to 8'h00.
REQ-024 i_TX_Done in IDLE or LOAD SHALL be ignored.
REQ-025 In WAIT, a cycle counter SHALL increment each clock; reaching TX_TIMEOUT sets o_Timeout=1 and returns the FSM to IDLE with no count increment.
REQ-026 o_Timeout SHALL be cleared only by reset.
REQ-027 An accept in the same cycle as the final i_TX_Done SHALL NOT occur, since o_Ready is still 0; o_Ready rises the next cycle.

Reset
REQ-028 On i_Rst=1, immediately and asynchronously: the FSM goes to IDLE, o_Ready=1, o_TX_DV=0, o_TX_Byte=8'h00, o_Frame_Count=0, o_Timeout=0, and the byte index and timeout counter are cleared.
REQ-029 Reset mid-frame SHALL abandon the frame with no further o_TX_DV; the host resyncs on HEADER.

Configuration
REQ-030 With RESULT_FRAMER_CHECKSUM_EN defined, the frame SHALL be 7 bytes; byte 7 is the XOR of the status byte and the four data bytes (HEADER excluded).
REQ-031 Without RESULT_FRAMER_CHECKSUM_EN, the frame SHALL be 6 bytes with no checksum logic.

Verification
REQ-032 Send status 8'h01 and result 32'h12345678 with a Done responder 10 clocks after each DV -> bytes A5,01,12,34,56,78 (plus 09 with checksum), then o_Frame_Count=1.
REQ-033 Pulse i_Result_DV mid-frame with 32'hDEADBEEF -> it is ignored and the in-flight frame's bytes are unchanged.
REQ-034 Send 256 frames back-to-back -> o_Frame_Count returns to 8'h00, and o_Ready is high exactly 1 cycle after each final Done.
REQ-035 Withhold i_TX_Done after the third byte -> o_Timeout=1 after TX_TIMEOUT clocks, the FSM is in IDLE, and o_Frame_Count is unchanged.
REQ-036 Assert i_Rst during the WAIT of byte 4 -> all outputs take reset values in the same cycle, and no o_TX_DV occurs until a new accept.
